// File: rtl/return_address_stack_pkg.sv
// Shared constants and stack-op encoding for the return address stack.
// The word width tracks the PC width so call/return targets fit the fetch PC exactly.
package return_address_stack_pkg;

  localparam int unsigned PC_WIDTH    = 12;
  localparam int unsigned WORD_LENGTH = PC_WIDTH;
  localparam int unsigned DEPTH       = 8;
  localparam int unsigned PTR_W       = $clog2(DEPTH);
  localparam int unsigned CNT_W       = PTR_W + 1;

  typedef enum logic [1:0] {
    OP_NOP     = 2'd0,
    OP_PUSH    = 2'd1,
    OP_POP     = 2'd2,
    OP_REPLACE = 2'd3
  } stackOp_e;

  // Map decode's push/pop strobes onto a stack operation.
  function automatic stackOp_e decodeOp(input logic push, input logic pop);
    stackOp_e op;
    unique case ({push, pop})
      2'b10:   op = OP_PUSH;
      2'b01:   op = OP_POP;
      2'b11:   op = OP_REPLACE;
      default: op = OP_NOP;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/return_address_stack_if.sv
// Decode/fetch-facing bundle of the return address stack.
// master = decode/fetch side, slave = the stack itself.
interface return_address_stack_if;
  import return_address_stack_pkg::*;

  logic                   push;
  logic                   pop;
  logic [WORD_LENGTH-1:0] dataIn;
  logic                   errClr;
  logic [WORD_LENGTH-1:0] stackOutput;
  logic                   empty;
  logic                   full;
  logic [CNT_W-1:0]       count;
  logic                   overflow;
  logic                   underflow;

  modport master (
    output push, pop, dataIn, errClr,
    input  stackOutput, empty, full, count, overflow, underflow
  );

  modport slave (
    input  push, pop, dataIn, errClr,
    output stackOutput, empty, full, count, overflow, underflow
  );

endinterface

// File: rtl/return_address_stack_regfile.sv
// Stack entry storage: one synchronous write port, one asynchronous read port,
// synchronous active-low clear of every entry.
module stack_regfile #(
  parameter int unsigned WIDTH = 12,
  parameter int unsigned DEPTH = 8,
  parameter int unsigned AW    = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wrEn,
  input  logic [AW-1:0]    wrAddr,
  input  logic [WIDTH-1:0] wrData,
  input  logic [AW-1:0]    rdAddr,
  output logic [WIDTH-1:0] rdData
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
    end else if (wrEn) begin
      mem[wrAddr] <= wrData;
    end
  end

  assign rdData = mem[rdAddr];

endmodule

// File: rtl/return_address_stack.sv
// Call/return stack feeding fetch: zero-latency top-of-stack read, replace on
// simultaneous push/pop, sticky overflow/underflow flags.
module return_address_stack
  import return_address_stack_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  return_address_stack_if.slave  ras
);

  logic [CNT_W-1:0]       sp;
  logic [CNT_W-1:0]       spNext;
  logic [CNT_W-1:0]       spMinus1;
  logic [PTR_W-1:0]       topIdx;
  logic                   isEmpty;
  logic                   isFull;
  logic                   wrEn;
  logic [PTR_W-1:0]       wrAddr;
  logic [WORD_LENGTH-1:0] rdData;
  logic                   ovfSet;
  logic                   udfSet;
  logic                   overflowQ;
  logic                   underflowQ;
  stackOp_e               op;

  assign spMinus1 = sp - CNT_W'(1);
  assign topIdx   = spMinus1[PTR_W-1:0];
  assign isEmpty  = (sp == '0);
  assign isFull   = (sp == CNT_W'(DEPTH));
  assign op       = decodeOp(ras.push, ras.pop);

  // Pointer movement, write-port steering and error-event detection.
  always_comb begin
    spNext = sp;
    wrEn   = 1'b0;
    wrAddr = sp[PTR_W-1:0];
    ovfSet = 1'b0;
    udfSet = 1'b0;
    unique case (op)
      OP_PUSH: begin
        if (isFull) begin
          ovfSet = 1'b1;
        end else begin
          wrEn   = 1'b1;
          spNext = sp + CNT_W'(1);
        end
      end
      OP_POP: begin
        if (isEmpty) udfSet = 1'b1;
        else         spNext = spMinus1;
      end
      OP_REPLACE: begin
        // Replacing on an empty stack degenerates to a plain push.
        wrEn = 1'b1;
        if (isEmpty) begin
          spNext = sp + CNT_W'(1);
        end else begin
          wrAddr = topIdx;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      sp         <= '0;
      overflowQ  <= 1'b0;
      underflowQ <= 1'b0;
    end else begin
      sp         <= spNext;
      overflowQ  <= ovfSet | (overflowQ & ~ras.errClr);
      underflowQ <= udfSet | (underflowQ & ~ras.errClr);
    end
  end

  stack_regfile #(
    .WIDTH (WORD_LENGTH),
    .DEPTH (DEPTH),
    .AW    (PTR_W)
  ) u_regfile (
    .clk    (clk),
    .rst    (rst),
    .wrEn   (wrEn),
    .wrAddr (wrAddr),
    .wrData (ras.dataIn),
    .rdAddr (topIdx),
    .rdData (rdData)
  );

  assign ras.stackOutput = isEmpty ? '0 : rdData;
  assign ras.empty       = isEmpty;
  assign ras.full        = isFull;
  assign ras.count       = sp;
  assign ras.overflow    = overflowQ;
  assign ras.underflow   = underflowQ;

endmodule

// File: tb/tb_return_address_stack.sv
// Randomized bench for return_address_stack against a queue-based LIFO model,
// with directed sequences pinning literal expectations.
module tb_return_address_stack;
  import return_address_stack_pkg::*;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  return_address_stack_if ras();

  return_address_stack dut (
    .clk (clk),
    .rst (rst),
    .ras (ras)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model: a queue whose back is the top of stack.
  logic [WORD_LENGTH-1:0] mdl[$];
  logic mdlOvf;
  logic mdlUdf;
  logic mdlValid;

  initial begin
    mdlValid = 1'b0;
    mdlOvf   = 1'b0;
    mdlUdf   = 1'b0;
  end

  always @(posedge clk) begin
    logic evOv;
    logic evUd;
    evOv = 1'b0;
    evUd = 1'b0;
    if (!rst) begin
      mdl.delete();
      mdlOvf   = 1'b0;
      mdlUdf   = 1'b0;
      mdlValid = 1'b1;
    end else if (mdlValid) begin
      if (ras.push && ras.pop) begin
        if (mdl.size() == 0) mdl.push_back(ras.dataIn);
        else                 mdl[mdl.size()-1] = ras.dataIn;
      end else if (ras.push) begin
        if (mdl.size() == int'(DEPTH)) evOv = 1'b1;
        else                           mdl.push_back(ras.dataIn);
      end else if (ras.pop) begin
        if (mdl.size() == 0) evUd = 1'b1;
        else                 void'(mdl.pop_back());
      end
      if (ras.errClr) begin
        mdlOvf = 1'b0;
        mdlUdf = 1'b0;
      end
      if (evOv) mdlOvf = 1'b1;
      if (evUd) mdlUdf = 1'b1;
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Cycle compare of every output against the model, away from the active edge.
  always @(negedge clk) begin
    if (mdlValid) begin
      int top;
      int sz;
      sz  = mdl.size();
      top = (sz == 0) ? 0 : int'(mdl[sz-1]);
      chk("cyc_stackOutput", int'(ras.stackOutput), top);
      chk("cyc_count",       int'(ras.count),       sz);
      chk("cyc_empty",       int'(ras.empty),       int'(sz == 0));
      chk("cyc_full",        int'(ras.full),        int'(sz == int'(DEPTH)));
      chk("cyc_overflow",    int'(ras.overflow),    int'(mdlOvf));
      chk("cyc_underflow",   int'(ras.underflow),   int'(mdlUdf));
    end
  end

  task automatic drive(input logic r, input logic pu, input logic po,
                       input logic [WORD_LENGTH-1:0] d, input logic c);
    @(posedge clk);
    #2;
    rst        = r;
    ras.push   = pu;
    ras.pop    = po;
    ras.dataIn = d;
    ras.errClr = c;
  endtask

  task automatic idle();
    drive(1'b1, 1'b0, 1'b0, '0, 1'b0);
  endtask

  initial begin
    checks     = 0;
    errors     = 0;
    rst        = 1'b0;
    ras.push   = 1'b0;
    ras.pop    = 1'b0;
    ras.dataIn = '0;
    ras.errClr = 1'b0;

    drive(1'b0, 1'b0, 1'b0, '0, 1'b0);
    idle();
    idle();
    chk("rst_top",   int'(ras.stackOutput), 0);
    chk("rst_empty", int'(ras.empty), 1);
    chk("rst_full",  int'(ras.full), 0);
    chk("rst_count", int'(ras.count), 0);
    chk("rst_ovf",   int'(ras.overflow), 0);
    chk("rst_udf",   int'(ras.underflow), 0);

    drive(1'b1, 1'b1, 1'b0, 12'h010, 1'b0);
    drive(1'b1, 1'b1, 1'b0, 12'h020, 1'b0);
    drive(1'b1, 1'b1, 1'b0, 12'h030, 1'b0);
    idle();
    chk("push3_top",   int'(ras.stackOutput), 'h030);
    chk("push3_count", int'(ras.count), 3);
    drive(1'b1, 1'b0, 1'b1, '0, 1'b0);
    chk("pop_top0", int'(ras.stackOutput), 'h030);
    drive(1'b1, 1'b0, 1'b1, '0, 1'b0);
    chk("pop_top1", int'(ras.stackOutput), 'h020);
    drive(1'b1, 1'b0, 1'b1, '0, 1'b0);
    chk("pop_top2", int'(ras.stackOutput), 'h010);
    idle();
    chk("pop_done_top",   int'(ras.stackOutput), 0);
    chk("pop_done_empty", int'(ras.empty), 1);

    for (int i = 0; i < 8; i++) drive(1'b1, 1'b1, 1'b0, WORD_LENGTH'(12'h100 + i), 1'b0);
    idle();
    chk("fill_full",  int'(ras.full), 1);
    chk("fill_count", int'(ras.count), 8);
    chk("fill_top",   int'(ras.stackOutput), 'h107);
    drive(1'b1, 1'b1, 1'b0, 12'h1FF, 1'b0);
    idle();
    chk("ovf_count", int'(ras.count), 8);
    chk("ovf_top",   int'(ras.stackOutput), 'h107);
    chk("ovf_flag",  int'(ras.overflow), 1);
    drive(1'b1, 1'b0, 1'b0, '0, 1'b1);
    idle();
    chk("ovf_clr", int'(ras.overflow), 0);

    for (int i = 0; i < 8; i++) drive(1'b1, 1'b0, 1'b1, '0, 1'b0);
    drive(1'b1, 1'b0, 1'b1, '0, 1'b0);
    idle();
    chk("udf_flag",  int'(ras.underflow), 1);
    chk("udf_count", int'(ras.count), 0);
    chk("udf_top",   int'(ras.stackOutput), 0);
    drive(1'b1, 1'b0, 1'b1, '0, 1'b1);
    idle();
    chk("udf_setwins", int'(ras.underflow), 1);
    drive(1'b1, 1'b0, 1'b0, '0, 1'b1);
    idle();

    drive(1'b1, 1'b1, 1'b0, 12'h0AA, 1'b0);
    drive(1'b1, 1'b1, 1'b0, 12'h0BB, 1'b0);
    drive(1'b1, 1'b1, 1'b1, 12'h0CC, 1'b0);
    idle();
    chk("repl_count", int'(ras.count), 2);
    chk("repl_top",   int'(ras.stackOutput), 'h0CC);
    chk("repl_flags", int'({ras.overflow, ras.underflow}), 0);
    drive(1'b1, 1'b0, 1'b1, '0, 1'b0);
    idle();
    chk("repl_next", int'(ras.stackOutput), 'h0AA);
    drive(1'b1, 1'b0, 1'b1, '0, 1'b0);
    drive(1'b1, 1'b1, 1'b1, 12'h0DD, 1'b0);
    idle();
    chk("repl_empty_count", int'(ras.count), 1);
    chk("repl_empty_top",   int'(ras.stackOutput), 'h0DD);
    chk("repl_empty_udf",   int'(ras.underflow), 0);

    for (int i = 0; i < 4; i++) drive(1'b1, 1'b1, 1'b0, WORD_LENGTH'(12'h200 + i), 1'b0);
    idle();
    chk("mid_pre_count", int'(ras.count), 5);
    drive(1'b0, 1'b1, 1'b0, 12'h777, 1'b0);
    idle();
    chk("mid_rst_count", int'(ras.count), 0);
    chk("mid_rst_top",   int'(ras.stackOutput), 0);
    chk("mid_rst_flags", int'({ras.overflow, ras.underflow}), 0);

    for (int n = 0; n < 3000; n++) begin
      int r;
      logic pu;
      logic po;
      r  = int'($urandom_range(0, 99));
      pu = (r < 50) || (r >= 90);
      po = (r >= 50);
      drive(($urandom_range(0, 127) != 0), pu, po,
            WORD_LENGTH'($urandom), ($urandom_range(0, 15) == 0));
    end
    idle();
    idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/return_address_stack.md
Name: return_address_stack

Overview:
- Hardware call/return stack that sits directly upstream of the fetch stage. It supplies that stage's 12-bit stackOutput PC source.
- On a call, decode pushes the return address (current PC + 1). On a return, decode pops, and fetch loads the top entry into the PC in the same cycle.
- Fixed-depth LIFO of register entries with full/empty status and sticky overflow/underflow error flags.

Parameters:
- WORD_LENGTH, 12, width of one stored return address (matches PC width).
- DEPTH, 8, number of entries; must be a power of two, at least 2.
- PTR_W, 3, log2(DEPTH); count width is PTR_W+1.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous reset, active-low (rst=0 at a rising edge resets).
- push  input  1  push dataIn this cycle.
- pop  input  1  pop top entry this cycle.
- dataIn  input  WORD_LENGTH  return address to push.
- errClr  input  1  clears sticky error flags.
- stackOutput  output  WORD_LENGTH  current top entry; 0 when empty.
- empty  output  1  count == 0.
- full  output  1  count == DEPTH.
- count  output  PTR_W+1  number of valid entries, 0..DEPTH.
- overflow  output  1  sticky: a push was dropped because the stack was full.
- underflow  output  1  sticky: a pop was issued while empty.

Behaviour:
- State: entry array mem[0..DEPTH-1], stack pointer sp (PTR_W+1 bits, equal to count), overflow and underflow flags. All state is registered and updates only at the rising clk edge.
- Reset: rst=0 at an edge sets sp=0, every mem entry to 0, and both flags to 0. After reset: stackOutput=0, empty=1, full=0, count=0. Reset overrides every other input, including mid-sequence.
- Read path: stackOutput = mem[sp-1] when sp != 0, else 0. It is combinational from registered state, so there is zero read latency. During a pop cycle, stackOutput shows the entry being popped, which lets fetch capture it into the PC at that same edge.
- push=1, pop=0, not full: mem[sp] <= dataIn; sp <= sp+1. The new top is visible on the next cycle.
- push=1, pop=0, full: stack unchanged; overflow <= 1 (the entry is dropped).
- pop=1, push=0, not empty: sp <= sp-1. The stale mem entry is left in place.
- pop=1, push=0, empty: stack unchanged; underflow <= 1; stackOutput stays 0.
- push=1, pop=1, not empty: replace the top, i.e. mem[sp-1] <= dataIn. sp is unchanged and no flag is set, even when full.
- push=1, pop=1, empty: acts as a plain push (sp <= 1); no underflow.
- push=0, pop=0: hold.
- errClr=1 clears both flags. If an error event occurs in the same cycle, the set wins.
- Width rules: the pointer never wraps. Indices sp and sp-1 are only used when in range, as guarded above.
- full and empty are derived combinationally from sp and are never both 1.

Decomposition:
- Shared package: DEPTH/WORD_LENGTH defaults (shared with the PC width constant), PTR_W derivation, and a 2-bit stack-op encoding {NOP, PUSH, POP, REPLACE} used by decode.
- One natural sub-module: stack_regfile, a DEPTH x WORD_LENGTH register array with a synchronous write port (wrEn, wrAddr, wrData), one asynchronous read port, and synchronous active-low clear.
- Pointer, flag and op-decode logic stay in return_address_stack.

Test Plan:
- Reset then idle: hold rst=0 for 2 cycles, release -> stackOutput=0, empty=1, full=0, count=0, overflow=0, underflow=0.
- Push then pop sequence: push 12'h010, 12'h020, 12'h030 -> stackOutput reads 030 with count=3. Pop three times -> stackOutput reads 030, 020, 010 on the respective pop cycles, then 0, with empty=1.
- Fill and overflow: push 12'h100 through 12'h107 -> full=1, count=8, top=107. Push 12'h1FF -> count stays 8, top stays 107, overflow=1. Pulse errClr -> overflow=0.
- Underflow: from empty, pop -> underflow=1, count=0, stackOutput=0. Assert errClr together with another pop -> underflow stays 1 (set wins).
- Simultaneous push and pop: with stack {0AA, 0BB}, push=pop=1 with dataIn=0CC -> count=2, top=0CC, next entry 0AA, no flags. On empty, push=pop=1 with 0DD -> count=1, top=0DD, underflow=0.
- Reset mid-operation: with 5 entries, drive rst=0 together with push=1 -> next cycle count=0, stackOutput=0, flags=0, and the pushed value is discarded.
